scan_line_window_bram: RTL and testbench
========================================

// Module: scan_line_window_bram
// PURPOSE
// Streaming 2-D neighbourhood extractor for raster-scanned pixels. Each accepted
// pixel is pushed into (block_height-1) block-RAM line buffers plus a register
// window, and a block_height x block_width window ending at the newest pixel is
// output flat. Feeds local-extremum / filter stages after the octave pipeline.
// PARAMETERS
// block_height  3    window rows (>=2)
// block_width   3    window columns (>=2)
// frame_width   640  pixels per image line = line-buffer depth
// pixel_depth   8    bits per pixel (treated as opaque, signedness irrelevant)
// PORTS
// clk        in   1    rising-edge clock, single clock domain
// rst        in   1    asynchronous, active-high reset
// en         in   1    pixel strobe; din accepted on rising clk while en=1
// din        in   pixel_depth                     incoming pixel
// win        out  block_height*block_width*pixel_depth  flattened window
// win_valid  out  1    every window slot holds a real sample since reset
// BEHAVIOUR
// - Sample index n = count of accepted pixels since reset (first = 0).
// - Slot (r,c), r=0..bh-1 top->bottom, c=0..bw-1 left->right, located at
//   win[(r*block_width+c)*pixel_depth +: pixel_depth].
// - After the en edge accepting sample N: slot(r,c) = sample
//   N-(bh-1-r)*frame_width-(bw-1-c); bottom-right slot = din just accepted.
// - Latency: win updates on the same clk edge that samples en=1 (registered).
// - en=0: win, pointer, RAM contents, fill counter all hold.
// - Line buffers: bh-1 RAMs, depth frame_width, one shared write pointer
//   0..frame_width-1, wraps to 0. Buffer0 writes din; buffer k writes buffer
//   k-1's read data at the same address. Column inserted at right edge:
//   row bh-1 = din, row bh-2-k = buffer k output.
// - RAM read is synchronous; prefetch read address = next write pointer so
//   data is ready for back-to-back en. Gaps in en must not corrupt ordering.
// - No frame/line awareness: window spans line ends and wraps across lines.
// - Reset: pointer=0, all win slots=0, win_valid=0, fill counter=0. RAM
//   contents are not cleared (masked by win_valid).
// - win_valid rises on the edge accepting sample (bh-1)*frame_width+bw-1,
//   stays 1 until rst. Fill counter saturates.
// - Reset mid-stream: immediate async clear of outputs; restart at index 0.
// TESTING
// - bh=bw=3, fw=8, 8-bit; din=n, en=1 for 30 pulses -> slot(2,2)=29,
//   slot(1,1)=20, slot(0,0)=11, slot(0,2)=13.
// - Same, count pulses -> win_valid=0 after 18 pulses, =1 after 19 with
//   slot(0,0)=0.
// - en toggled 1,0,0,1 over ramp -> win identical to continuous-en result
//   after same number of accepted pixels; holds while en=0.
// - Run 40 pulses, assert rst for 1 cycle -> win=0, win_valid=0; restart
//   ramp from 0 -> after 19 pulses slot(0,0)=0, slot(2,2)=18.
// - Pointer wrap: 3*fw+5 pulses -> slot(1,1)=N-9 exact across wrap, no
//   stale data (N=last index).
// - fw=640 default, 2000 random pixels -> every slot matches software model.

Source files
------------

// File: rtl/scan_line_window_bram.sv
// Streaming block_height x block_width neighbourhood window over raster-scanned pixels.
// Line history comes from cascaded block-RAM line buffers that share one write pointer.
module scan_line_window_bram #(
  parameter int unsigned block_height = 3,
  parameter int unsigned block_width  = 3,
  parameter int unsigned frame_width  = 640,
  parameter int unsigned pixel_depth  = 8
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          en,
  input  logic [pixel_depth-1:0]                        din,
  output logic [block_height*block_width*pixel_depth-1:0] win,
  output logic                                          win_valid
);

  localparam int unsigned NumBuf     = block_height - 1;
  localparam int unsigned PtrW       = (frame_width > 1) ? $clog2(frame_width) : 1;
  localparam int unsigned FillTarget = (block_height - 1) * frame_width + block_width - 1;
  localparam int unsigned CntW       = $clog2(FillTarget + 1);
  localparam int unsigned WinW       = block_height * block_width * pixel_depth;

  typedef logic [pixel_depth-1:0] pix_t;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_addr;
  logic [CntW-1:0] fill_q, fill_d;
  logic            valid_q, valid_d;
  logic [WinW-1:0] win_q, win_d;
  pix_t            rd_data [NumBuf];
  pix_t            col     [block_height];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (en) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(frame_width - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
  end

  // Prefetch the slot the next accepted pixel will overwrite; with en low this
  // re-reads the current slot, so gaps in en leave the read data consistent.
  assign rd_addr = wr_ptr_d;

  for (genvar k = 0; k < NumBuf; k++) begin : gen_buf
    pix_t mem [frame_width];
    pix_t rd_q;
    pix_t wdata;

    if (k == 0) begin : gen_head
      assign wdata = din;
    end else begin : gen_tail
      assign wdata = rd_data[k-1];
    end

    always_ff @(posedge clk) begin
      if (en) begin
        mem[wr_ptr_q] <= wdata;
      end
      rd_q <= mem[rd_addr];
    end

    assign rd_data[k] = rd_q;
  end

  always_comb begin
    col[block_height-1] = din;
    for (int unsigned k = 0; k < NumBuf; k++) begin
      col[block_height-2-k] = rd_data[k];
    end
  end

  always_comb begin
    win_d = win_q;
    if (en) begin
      for (int unsigned r = 0; r < block_height; r++) begin
        for (int unsigned c = 0; c < block_width; c++) begin
          if (c < block_width - 1) begin
            win_d[(r*block_width+c)*pixel_depth +: pixel_depth] =
                win_q[(r*block_width+c+1)*pixel_depth +: pixel_depth];
          end else begin
            win_d[(r*block_width+c)*pixel_depth +: pixel_depth] = col[r];
          end
        end
      end
    end
  end

  // fill_q holds the index of the next sample; it stops once the window is full.
  always_comb begin
    fill_d  = fill_q;
    valid_d = valid_q;
    if (en) begin
      if (fill_q == CntW'(FillTarget)) begin
        valid_d = 1'b1;
      end else begin
        fill_d = fill_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
      valid_q  <= 1'b0;
      win_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      valid_q  <= valid_d;
      win_q    <= win_d;
    end
  end

  assign win       = win_q;
  assign win_valid = valid_q;

endmodule

// File: tb/tb_scan_line_window_bram.sv
// Scoreboard bench: a small-line (fw=8) and a default-line (fw=640) instance,
// each checked every cycle against a software window model.
module tb_scan_line_window_bram;

  localparam int Bh = 3;
  localparam int Bw = 3;
  localparam int Pd = 8;
  localparam int FwA = 8;
  localparam int FwB = 640;
  localparam int WinW = Bh * Bw * Pd;

  logic            clk = 1'b0;
  logic            rst_a, rst_b, en_a, en_b, valid_a, valid_b;
  logic [Pd-1:0]   din_a, din_b;
  logic [WinW-1:0] win_a, win_b;

  typedef struct {
    bit           sel;
    logic [127:0] win;
    logic         valid;
  } sb_t;

  sb_t sb[$];
  int  hist_a[$];
  int  hist_b[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  always #5 clk = ~clk;

  scan_line_window_bram #(
    .block_height(Bh), .block_width(Bw), .frame_width(FwA), .pixel_depth(Pd)
  ) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .din(din_a), .win(win_a), .win_valid(valid_a)
  );

  scan_line_window_bram #(
    .block_height(Bh), .block_width(Bw), .frame_width(FwB), .pixel_depth(Pd)
  ) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .din(din_b), .win(win_b), .win_valid(valid_b)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [127:0] calc_win(input bit sel);
    logic [127:0] w = '0;
    int fw = sel ? FwB : FwA;
    int n  = (sel ? hist_b.size() : hist_a.size()) - 1;
    for (int r = 0; r < Bh; r++) begin
      for (int c = 0; c < Bw; c++) begin
        int idx = n - (Bh - 1 - r) * fw - (Bw - 1 - c);
        if (idx >= 0) w[(r*Bw+c)*Pd +: Pd] = Pd'(sel ? hist_b[idx] : hist_a[idx]);
      end
    end
    return w;
  endfunction

  function automatic logic [Pd-1:0] slot(input logic [WinW-1:0] w, input int r, input int c);
    return w[(r*Bw+c)*Pd +: Pd];
  endfunction

  // One clock: drive at negedge, push the model's expectation, compare after the edge.
  task automatic step(input bit sel, input bit en_v, input logic [Pd-1:0] d);
    sb_t e;
    @(negedge clk);
    if (sel) begin
      en_b = en_v; din_b = d;
      if (en_v) hist_b.push_back(int'(d));
    end else begin
      en_a = en_v; din_a = d;
      if (en_v) hist_a.push_back(int'(d));
    end
    e.sel   = sel;
    e.win   = calc_win(sel);
    e.valid = sel ? (hist_b.size() >= 2*FwB + Bw) : (hist_a.size() >= 2*FwA + Bw);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.sel) begin
      check_eq("valid_b", 128'(valid_b), 128'(e.valid));
      if (e.valid) check_eq("win_b", 128'(win_b), e.win);
      en_b = 1'b0;
    end else begin
      check_eq("valid_a", 128'(valid_a), 128'(e.valid));
      if (e.valid) check_eq("win_a", 128'(win_a), e.win);
      en_a = 1'b0;
    end
  endtask

  task automatic reset_a();
    @(negedge clk);
    #2 rst_a = 1'b1;
    #1;
    check_eq("rst_win_a", 128'(win_a), 128'd0);
    check_eq("rst_valid_a", 128'(valid_a), 128'd0);
    hist_a.delete();
    @(posedge clk);
    #1 rst_a = 1'b0;
  endtask

  initial begin
    int acc;
    rst_a = 1'b1; rst_b = 1'b1;
    en_a = 1'b0; en_b = 1'b0; din_a = '0; din_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("init_win_a", 128'(win_a), 128'd0);
    check_eq("init_valid_a", 128'(valid_a), 128'd0);
    check_eq("init_win_b", 128'(win_b), 128'd0);
    check_eq("init_valid_b", 128'(valid_b), 128'd0);
    rst_a = 1'b0; rst_b = 1'b0;

    // Continuous ramp, 30 pulses.
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, Pd'(i));
    check_eq("ramp_s22", 128'(slot(win_a, 2, 2)), 128'd29);
    check_eq("ramp_s11", 128'(slot(win_a, 1, 1)), 128'd20);
    check_eq("ramp_s00", 128'(slot(win_a, 0, 0)), 128'd11);
    check_eq("ramp_s02", 128'(slot(win_a, 0, 2)), 128'd13);

    // Same ramp with en gaps; junk din while en is low must be ignored.
    reset_a();
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b1, Pd'(i));
      step(1'b0, 1'b0, Pd'($urandom));
      step(1'b0, 1'b0, Pd'($urandom));
    end
    check_eq("gap_s22", 128'(slot(win_a, 2, 2)), 128'd29);
    check_eq("gap_s11", 128'(slot(win_a, 1, 1)), 128'd20);
    check_eq("gap_s00", 128'(slot(win_a, 0, 0)), 128'd11);

    // Mid-stream reset then restart from index 0.
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, Pd'(100 + i));
    reset_a();
    for (int i = 0; i < 19; i++) step(1'b0, 1'b1, Pd'(i));
    check_eq("rst_restart_valid", 128'(valid_a), 128'd1);
    check_eq("rst_restart_s00", 128'(slot(win_a, 0, 0)), 128'd0);
    check_eq("rst_restart_s22", 128'(slot(win_a, 2, 2)), 128'd18);

    // Pointer wrap with random data.
    reset_a();
    for (int i = 0; i < 3*FwA + 5; i++) step(1'b0, 1'b1, Pd'($urandom));
    check_eq("wrap_s11", 128'(slot(win_a, 1, 1)), 128'(hist_a[hist_a.size() - 1 - 9]));

    // Default line length, 2000 random pixels with random strobe gaps.
    acc = 0;
    while (acc < 2000) begin
      bit e_v = ($urandom_range(0, 9) != 0);
      step(1'b1, e_v, Pd'($urandom));
      if (e_v) acc++;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
